// File: rtl/matmul_mkn_seq_if.sv
// Operand/result handshake bundle for matmul_mkn_seq.
// The master drives operands and out_ready. The slave (the multiplier) drives results and in_ready.
interface matmul_mkn_seq_if #(
  parameter int unsigned M     = 4,
  parameter int unsigned K     = 3,
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 2 * DW + $clog2(K)
);
  logic                   in_valid;
  logic                   in_ready;
  logic [M*K*DW-1:0]      a_mtx;
  logic [K*N*DW-1:0]      b_mtx;
  logic                   out_valid;
  logic                   out_ready;
  logic [M*N*ACC_W-1:0]   result_mtx;

  modport master (
    output in_valid, a_mtx, b_mtx, out_ready,
    input  in_ready, out_valid, result_mtx
  );

  modport slave (
    input  in_valid, a_mtx, b_mtx, out_ready,
    output in_ready, out_valid, result_mtx
  );
endinterface

// File: rtl/matmul_mkn_seq.sv
// Sequential C = A(MxK) * B(KxN) multiplier.
// N parallel MAC lanes produce one row of C every K cycles.
module matmul_mkn_seq #(
  parameter int unsigned M      = 4,
  parameter int unsigned K      = 3,
  parameter int unsigned N      = 3,
  parameter int unsigned DW     = 8,
  parameter bit          SIGNED = 1'b0
) (
  input logic             clk,
  input logic             rstn,
  matmul_mkn_seq_if.slave bus
);
  localparam int unsigned ACC_W = 2 * DW + $clog2(K);
  localparam int unsigned IW    = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                 state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [KW-1:0]          k_q, k_d;
  logic [M*K*DW-1:0]      a_q, a_d;
  logic [K*N*DW-1:0]      b_q, b_d;
  logic [M*N*ACC_W-1:0]   res_q, res_d;
  logic [ACC_W-1:0]       acc_q [N];
  logic [ACC_W-1:0]       acc_d [N];
  logic [ACC_W-1:0]       sum   [N];

  function automatic logic [ACC_W-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED) ext = {{(ACC_W-DW){v[DW-1]}}, v};
    else        ext = {{(ACC_W-DW){1'b0}}, v};
  endfunction

  // Operands are extended before multiplying, so the ACC_W-wide product is exact in both modes.
  always_comb begin
    for (int unsigned j = 0; j < N; j++) begin
      sum[j] = acc_q[j] + ext(a_q[(32'(i_q) * K + 32'(k_q)) * DW +: DW])
                        * ext(b_q[(32'(k_q) * N + j) * DW +: DW]);
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    for (int unsigned j = 0; j < N; j++) acc_d[j] = acc_q[j];

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a_mtx;
          b_d     = bus.b_mtx;
          i_d     = '0;
          k_d     = '0;
          for (int unsigned j = 0; j < N; j++) acc_d[j] = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (k_q == KW'(K - 1)) begin
          // Last inner step: the row takes the fresh sum, not the stale accumulator.
          for (int unsigned j = 0; j < N; j++) begin
            res_d[(32'(i_q) * N + j) * ACC_W +: ACC_W] = sum[j];
            acc_d[j] = '0;
          end
          k_d = '0;
          if (i_q == IW'(M - 1)) begin
            i_d     = '0;
            state_d = StDone;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          for (int unsigned j = 0; j < N; j++) acc_d[j] = sum[j];
          k_d = k_q + KW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      i_q     <= '0;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      for (int unsigned j = 0; j < N; j++) acc_q[j] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      for (int unsigned j = 0; j < N; j++) acc_q[j] <= acc_d[j];
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.result_mtx = res_q;
endmodule

// File: tb/tb_matmul_mkn_seq.sv
// Bench for matmul_mkn_seq: a signed and an unsigned instance.
// Expected matrices are queued at acceptance and compared on each output handshake.
module tb_matmul_mkn_seq;
  localparam int unsigned M     = 4;
  localparam int unsigned K     = 3;
  localparam int unsigned N     = 3;
  localparam int unsigned DW    = 8;
  localparam int unsigned ACC_W = 2 * DW + $clog2(K);
  localparam int unsigned AW    = M * K * DW;
  localparam int unsigned BW    = K * N * DW;
  localparam int unsigned RW    = M * N * ACC_W;
  localparam int unsigned NV    = 4;

  typedef int ai_t [M*K];
  typedef int bi_t [K*N];
  typedef int ci_t [M*N];
  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [RW-1:0] c;
  } vec_t;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   ov_cnt_s = 0;
  logic [RW-1:0] exp_s [$];
  logic [RW-1:0] exp_u [$];
  vec_t vecs [NV];

  matmul_mkn_seq_if #(.M(M), .K(K), .N(N), .DW(DW), .ACC_W(ACC_W)) bus_s ();
  matmul_mkn_seq_if #(.M(M), .K(K), .N(N), .DW(DW), .ACC_W(ACC_W)) bus_u ();

  matmul_mkn_seq #(.M(M), .K(K), .N(N), .DW(DW), .SIGNED(1'b1)) dut_s (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_s)
  );

  matmul_mkn_seq #(.M(M), .K(K), .N(N), .DW(DW), .SIGNED(1'b0)) dut_u (
    .clk (clk),
    .rstn(rstn),
    .bus (bus_u)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout or unexpected event", name);
  endtask

  // Output monitors: every accepted result must match the oldest queued expectation.
  initial forever begin
    @(negedge clk);
    if (rstn && bus_s.out_valid) begin
      ov_cnt_s++;
      if (bus_s.out_ready) begin
        if (exp_s.size() == 0) fail_now("unexpected_out_s");
        else check("result_s", bus_s.result_mtx, exp_s.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rstn && bus_u.out_valid && bus_u.out_ready) begin
      if (exp_u.size() == 0) fail_now("unexpected_out_u");
      else check("result_u", bus_u.result_mtx, exp_u.pop_front());
    end
  end

  function automatic logic [AW-1:0] pack_a(input ai_t v);
    pack_a = '0;
    for (int e = 0; e < M * K; e++) pack_a[e*DW +: DW] = DW'(v[e]);
  endfunction

  function automatic logic [BW-1:0] pack_b(input bi_t v);
    pack_b = '0;
    for (int e = 0; e < K * N; e++) pack_b[e*DW +: DW] = DW'(v[e]);
  endfunction

  function automatic logic [RW-1:0] pack_c(input ci_t v);
    pack_c = '0;
    for (int e = 0; e < M * N; e++) pack_c[e*ACC_W +: ACC_W] = ACC_W'(v[e]);
  endfunction

  function automatic int elem(input logic [DW-1:0] x, input bit sgn);
    if (sgn) elem = int'({{(32-DW){x[DW-1]}}, x});
    else     elem = int'({{(32-DW){1'b0}}, x});
  endfunction

  function automatic logic [RW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                          input bit sgn);
    ci_t c;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        c[i*N+j] = 0;
        for (int k = 0; k < K; k++) begin
          c[i*N+j] += elem(a[(i*K+k)*DW +: DW], sgn) * elem(b[(k*N+j)*DW +: DW], sgn);
        end
      end
    end
    model = pack_c(c);
  endfunction

  // Called #1 after a clock edge; returns #1 after the accepting edge.
  task automatic issue_s(input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic [RW-1:0] exp, input bit push, output int c0);
    int n = 0;
    bus_s.a_mtx    = a;
    bus_s.b_mtx    = b;
    bus_s.in_valid = 1'b1;
    while (!bus_s.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_s.in_ready) fail_now("in_ready_timeout");
    @(posedge clk);
    if (push) exp_s.push_back(exp);
    #1;
    c0 = cyc;
    bus_s.in_valid = 1'b0;
  endtask

  task automatic wait_done_s(input int c0, input string name);
    int n = 0;
    while (!bus_s.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_s.out_valid) fail_now(name);
    else check(name, RW'(cyc - c0), RW'(M * K));
  endtask

  initial begin
    ai_t ta;
    bi_t tb;
    ci_t tc;
    logic [RW-1:0] exp_all;
    int c0, c1, n;

    ta = '{2, 0, 0, 1, 1, 1, 1, -1, 1, 0, 0, 2};
    tb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    tc = '{2, 4, 6, 12, 15, 18, 4, 5, 6, 14, 16, 18};
    vecs[0].a = pack_a(ta);
    vecs[0].b = pack_b(tb);
    vecs[0].c = pack_c(tc);
    for (int e = 0; e < M * K; e++) ta[e] = -128;
    for (int e = 0; e < K * N; e++) tb[e] = 127;
    for (int e = 0; e < M * N; e++) tc[e] = -48768;
    vecs[1].a = pack_a(ta);
    vecs[1].b = pack_b(tb);
    vecs[1].c = pack_c(tc);
    for (int v = 2; v < NV; v++) begin
      for (int e = 0; e < M * K; e++) vecs[v].a[e*DW +: DW] = DW'($urandom);
      for (int e = 0; e < K * N; e++) vecs[v].b[e*DW +: DW] = DW'($urandom);
      vecs[v].c = model(vecs[v].a, vecs[v].b, 1'b1);
    end

    rstn = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.out_ready = 1'b1; bus_s.a_mtx = '0; bus_s.b_mtx = '0;
    bus_u.in_valid = 1'b0; bus_u.out_ready = 1'b1; bus_u.a_mtx = '0; bus_u.b_mtx = '0;
    #2;
    check("rst_in_ready", RW'(bus_s.in_ready), RW'(1));
    check("rst_out_valid", RW'(bus_s.out_valid), RW'(0));
    check("rst_result", bus_s.result_mtx, '0);
    check("rst_result_u", bus_u.result_mtx, '0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // Unsigned extreme: 3 * 255 * 255 in every element.
    for (int e = 0; e < M * N; e++) exp_all[e*ACC_W +: ACC_W] = ACC_W'(195075);
    bus_u.a_mtx = '1;
    bus_u.b_mtx = '1;
    bus_u.in_valid = 1'b1;
    @(posedge clk);
    exp_u.push_back(exp_all);
    #1;
    c0 = cyc;
    bus_u.in_valid = 1'b0;
    n = 0;
    while (!bus_u.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus_u.out_valid) fail_now("lat_u");
    else check("lat_u", RW'(cyc - c0), RW'(M * K));
    @(posedge clk); #1;

    for (int v = 0; v < NV; v++) begin
      issue_s(vecs[v].a, vecs[v].b, vecs[v].c, 1'b1, c0);
      wait_done_s(c0, $sformatf("lat_vec%0d", v));
      @(posedge clk); #1;
      check($sformatf("idle_ready_vec%0d", v), RW'(bus_s.in_ready), RW'(1));
    end

    // Asynchronous reset in IDLE with a held result: clears without a clock edge.
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_result", bus_s.result_mtx, '0);
    check("async_rst_in_ready", RW'(bus_s.in_ready), RW'(1));
    check("async_rst_out_valid", RW'(bus_s.out_valid), RW'(0));
    @(posedge clk); #1;
    rstn = 1'b1;

    // Reset during the 5th CALC cycle aborts the operation.
    issue_s(vecs[0].a, vecs[0].b, vecs[0].c, 1'b0, c0);
    repeat (4) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("mid_rst_result", bus_s.result_mtx, '0);
    check("mid_rst_in_ready", RW'(bus_s.in_ready), RW'(1));
    check("mid_rst_out_valid", RW'(bus_s.out_valid), RW'(0));
    @(posedge clk); #1;
    rstn = 1'b1;
    n = 0;
    for (int t = 0; t < 15; t++) begin
      @(posedge clk); #1;
      if (bus_s.out_valid) n++;
    end
    check("mid_rst_no_pulse", RW'(n), RW'(0));
    issue_s(vecs[0].a, vecs[0].b, vecs[0].c, 1'b1, c0);
    wait_done_s(c0, "lat_rerun");
    @(posedge clk); #1;

    // Backpressure: result held for 20 cycles, in_valid pulse ignored.
    bus_s.out_ready = 1'b0;
    issue_s(vecs[0].a, vecs[0].b, vecs[0].c, 1'b1, c0);
    wait_done_s(c0, "lat_bp");
    for (int t = 0; t < 20; t++) begin
      check("bp_out_valid", RW'(bus_s.out_valid), RW'(1));
      check("bp_in_ready", RW'(bus_s.in_ready), RW'(0));
      check("bp_result", bus_s.result_mtx, vecs[0].c);
      if (t == 5) begin
        bus_s.a_mtx = vecs[1].a;
        bus_s.b_mtx = vecs[1].b;
        bus_s.in_valid = 1'b1;
      end
      if (t == 6) bus_s.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus_s.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", RW'(bus_s.out_valid), RW'(0));
    check("bp_release_in_ready", RW'(bus_s.in_ready), RW'(1));
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back with in_valid held and out_ready tied high.
    ov_cnt_s = 0;
    bus_s.a_mtx = vecs[2].a;
    bus_s.b_mtx = vecs[2].b;
    bus_s.in_valid = 1'b1;
    @(posedge clk);
    exp_s.push_back(vecs[2].c);
    #1;
    c0 = cyc;
    bus_s.a_mtx = vecs[3].a;
    bus_s.b_mtx = vecs[3].b;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus_s.in_ready && n < 100);
    if (!bus_s.in_ready) fail_now("b2b_second_accept");
    @(posedge clk);
    exp_s.push_back(vecs[3].c);
    #1;
    c1 = cyc;
    bus_s.in_valid = 1'b0;
    check("b2b_interval", RW'(c1 - c0), RW'(M * K + 2));
    wait_done_s(c1, "lat_b2b");
    repeat (3) @(posedge clk);
    #1;
    check("b2b_pulse_count", RW'(ov_cnt_s), RW'(2));

    check("queue_s_empty", RW'(exp_s.size()), RW'(0));
    check("queue_u_empty", RW'(exp_u.size()), RW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
